// File: rtl/click_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : click_count_ctrl
//  Purpose  : Two-button BCD up/down counter (00-99) with press-and-hold
//             auto-repeat. A fresh press steps once; holding the button for
//             REPEAT_DELAY cycles starts auto-repeat every REPEAT_RATE
//             cycles. Pressing both buttons, or the opposite button while
//             holding one, locks out stepping until both are released.
//  Ports    : CLK    - clock, rising edge
//             RST    - asynchronous active-high reset
//             UP_IN  - debounced up-button level (1 = pressed)
//             DN_IN  - debounced down-button level (1 = pressed)
//             TENS   - BCD tens digit (registered)
//             ONES   - BCD ones digit (registered)
//             STEP   - one-cycle pulse coincident with a new count
//             DIR    - direction of last step (1 = up, 0 = down)
//  Revision : 1.0  initial release
// ============================================================================
module click_count_ctrl #(
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 2500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UP_IN,
    input  logic       DN_IN,
    output logic [3:0] TENS,
    output logic [3:0] ONES,
    output logic       STEP,
    output logic       DIR
);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        ARM      = 2'd2,
        RPT      = 2'd3
    } state_t;

    localparam logic [23:0] c_delay_last = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] c_rate_last  = 24'(REPEAT_RATE - 1);

    state_t      r_state;
    logic [23:0] r_timer;
    logic        r_hdir;     // direction of the button being held
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;
    logic        r_step;
    logic        r_dir;

    logic        w_held;     // the held button is still pressed
    logic        w_opp;      // the opposite button is pressed
    logic [23:0] w_last;     // terminal timer value for the current state

    assign w_held = r_hdir ? UP_IN : DN_IN;
    assign w_opp  = r_hdir ? DN_IN : UP_IN;
    assign w_last = (r_state == ARM) ? c_delay_last : c_rate_last;

    // Next BCD value {tens, ones} one step up or down, wrapping 99 <-> 00.
    function automatic logic [7:0] bcd_next(input logic [3:0] t,
                                            input logic [3:0] o,
                                            input logic       up);
        logic [3:0] nt;
        logic [3:0] no;
        nt = t;
        no = o;
        if (up) begin
            if (o == 4'd9) begin
                no = 4'd0;
                nt = (t == 4'd9) ? 4'd0 : t + 4'd1;
            end else begin
                no = o + 4'd1;
            end
        end else begin
            if (o == 4'd0) begin
                no = 4'd9;
                nt = (t == 4'd0) ? 4'd9 : t - 4'd1;
            end else begin
                no = o - 4'd1;
            end
        end
        return {nt, no};
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= WAIT_REL;
            r_timer <= 24'd0;
            r_hdir  <= 1'b1;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_step  <= 1'b0;
            r_dir   <= 1'b1;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                WAIT_REL: begin
                    r_timer <= 24'd0;
                    if (!UP_IN && !DN_IN) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    r_timer <= 24'd0;
                    if (UP_IN && DN_IN) begin
                        r_state <= WAIT_REL;
                    end else if (UP_IN || DN_IN) begin
                        // UP_IN alone selects up, otherwise DN_IN alone
                        r_hdir           <= UP_IN;
                        r_dir            <= UP_IN;
                        r_step           <= 1'b1;
                        {r_tens, r_ones} <= bcd_next(r_tens, r_ones, UP_IN);
                        r_state          <= ARM;
                    end
                end
                ARM, RPT: begin
                    // Opposite button outranks both release and timer expiry.
                    if (w_opp) begin
                        r_timer <= 24'd0;
                        r_state <= WAIT_REL;
                    end else if (!w_held) begin
                        r_timer <= 24'd0;
                        r_state <= IDLE;
                    end else if (r_timer == w_last) begin
                        r_timer          <= 24'd0;
                        r_dir            <= r_hdir;
                        r_step           <= 1'b1;
                        {r_tens, r_ones} <= bcd_next(r_tens, r_ones, r_hdir);
                        r_state          <= RPT;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                default: begin
                    r_timer <= 24'd0;
                    r_state <= WAIT_REL;
                end
            endcase
        end
    end

    assign TENS = r_tens;
    assign ONES = r_ones;
    assign STEP = r_step;
    assign DIR  = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_click_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_click_count_ctrl
//  Purpose  : Self-checking bench for click_count_ctrl. Stimulus computes the
//             expected step events from a press-age model of the button
//             behaviour and queues them; a monitor compares every STEP pulse
//             (and every missing one) against the queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_click_count_ctrl;

    localparam int D = 8;
    localparam int R = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       UP_IN = 1'b0;
    logic       DN_IN = 1'b0;
    logic [3:0] TENS;
    logic [3:0] ONES;
    logic       STEP;
    logic       DIR;

    click_count_ctrl #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .UP_IN(UP_IN),
        .DN_IN(DN_IN),
        .TENS (TENS),
        .ONES (ONES),
        .STEP (STEP),
        .DIR  (DIR)
    );

    always #5 CLK = ~CLK;

    int cyc_cnt = 0;
    always @(posedge CLK) cyc_cnt++;

    typedef struct {
        int         cyc;
        logic [3:0] t;
        logic [3:0] o;
        logic       d;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: counts as an integer; a press is tracked by its age
    // in sampled cycles since it was first seen.
    bit m_locked;
    int m_held;     // 0 none, 1 up, 2 down
    int m_age;
    int m_count;
    bit m_dir;

    function automatic void model_reset();
        m_locked = 1'b1;
        m_held   = 0;
        m_age    = 0;
        m_count  = 0;
        m_dir    = 1'b1;
        q.delete();
    endfunction

    function automatic void model_edge(input bit up, input bit dn);
        bit   do_step = 1'b0;
        bit   sdir    = 1'b0;
        exp_t e;
        if (m_locked) begin
            if (!up && !dn) m_locked = 1'b0;
        end else if (m_held == 0) begin
            if (up && dn) begin
                m_locked = 1'b1;
            end else if (up || dn) begin
                m_held  = up ? 1 : 2;
                m_age   = 0;
                do_step = 1'b1;
                sdir    = up;
            end
        end else begin
            bit held_pressed = (m_held == 1) ? up : dn;
            bit opp_pressed  = (m_held == 1) ? dn : up;
            if (opp_pressed) begin
                m_locked = 1'b1;
                m_held   = 0;
            end else if (!held_pressed) begin
                m_held = 0;
            end else begin
                m_age++;
                if (m_age == D || (m_age > D && ((m_age - D) % R) == 0)) begin
                    do_step = 1'b1;
                    sdir    = (m_held == 1);
                end
            end
        end
        if (do_step) begin
            m_count = sdir ? (m_count + 1) % 100 : (m_count + 99) % 100;
            m_dir   = sdir;
            e.cyc = cyc_cnt + 1;
            e.t   = 4'(m_count / 10);
            e.o   = 4'(m_count % 10);
            e.d   = sdir;
            q.push_back(e);
        end
    endfunction

    // Monitor: every STEP must match the queue head scheduled for this edge,
    // and a scheduled step that does not appear is reported.
    always @(negedge CLK) begin
        exp_t e;
        if (STEP) begin
            n_checks++;
            if (q.size() > 0 && q[0].cyc == cyc_cnt) begin
                e = q.pop_front();
                if (TENS !== e.t || ONES !== e.o || DIR !== e.d) begin
                    n_fail++;
                    $display("FAIL step_value cyc=%0d got %0d%0d dir=%0b, expected %0d%0d dir=%0b",
                             cyc_cnt, TENS, ONES, DIR, e.t, e.o, e.d);
                end
            end else begin
                n_fail++;
                $display("FAIL unexpected_step cyc=%0d got STEP=1 count=%0d%0d, expected STEP=0",
                         cyc_cnt, TENS, ONES);
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_step cyc=%0d got STEP=0, expected STEP=1 count=%0d%0d",
                     cyc_cnt, e.t, e.o);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit up, input bit dn);
        @(negedge CLK);
        #1;
        UP_IN = up;
        DN_IN = dn;
        model_edge(up, dn);
    endtask

    task automatic press(input bit up, input bit dn, input int len);
        for (int i = 0; i < len; i++) drive(up, dn);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    // Call only after idle cycles so every step is already visible.
    task automatic check_count(input string name);
        @(negedge CLK);
        #2;
        chk(name, int'(TENS) * 10 + int'(ONES), m_count);
        chk({name, "_dir"}, int'(DIR), int'(m_dir));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1;
        RST = 1'b1;
        model_reset();
        #1;
        chk("rst_tens", int'(TENS), 0);
        chk("rst_ones", int'(ONES), 0);
        chk("rst_step", int'(STEP), 0);
        chk("rst_dir",  int'(DIR),  1);
        repeat (2) @(negedge CLK);
        #1;
        RST = 1'b0;
        model_edge(UP_IN, DN_IN);
    endtask

    initial begin
        model_reset();
        do_reset();
        drive(1'b0, 1'b0);

        // Short press
        press(1'b1, 1'b0, 3);
        check_count("short_press");

        // Down wrap 00 -> 99, up wrap 99 -> 00
        press(1'b0, 1'b1, 1);
        press(1'b0, 1'b1, 2);
        check_count("down_wrap");
        press(1'b1, 1'b0, 2);
        check_count("up_wrap");
        press(1'b0, 1'b1, 1);
        check_count("down_wrap2");
        press(1'b1, 1'b0, 1);

        // Auto-repeat from 00
        press(1'b1, 1'b0, 21);
        check_count("auto_repeat");

        // Simultaneous press rejected, then a clean press
        press(1'b1, 1'b1, 3);
        check_count("simultaneous");
        press(1'b1, 1'b0, 2);
        check_count("after_simul");

        // Opposite button during repeat freezes the count
        for (int i = 0; i < 14; i++) drive(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);
        press(1'b0, 1'b0, 1);
        check_count("opposite_freeze");

        // Button held through reset release
        drive(1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0);
        press(1'b0, 1'b0, 1);
        check_count("held_through_reset");
        press(1'b1, 1'b0, 1);
        check_count("repress_after_reset");

        // Reset mid-repeat
        for (int i = 0; i < 14; i++) drive(1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0);
        press(1'b0, 1'b0, 1);
        check_count("reset_mid_rpt");

        // Randomized runs
        for (int k = 0; k < 60; k++) begin
            int  kind = $urandom_range(0, 9);
            int  len  = $urandom_range(1, 24);
            bit  up   = (kind < 5) || (kind == 8);
            bit  dn   = (kind >= 5 && kind < 8) || (kind == 8);
            if (kind == 9) begin
                if ($urandom_range(0, 1) == 1) do_reset();
                else for (int i = 0; i < len; i++) drive(1'($urandom), 1'($urandom));
            end else begin
                for (int i = 0; i < len; i++) drive(up, dn);
                if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0);
            end
        end
        press(1'b0, 1'b0, 2);
        check_count("random_final");

        repeat (2) @(negedge CLK);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
